// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I instruction encoder.
// Turns a decoded instruction description into the 32-bit machine word, with
// valid/ready on both sides and a registered output stage.
// Build option: define INSTR_ENC_LI_EN to enable the `li` pseudo-instruction
// (class 9), which expands to one or two words through the LI_LO state.
// Without it, class 9 is handled like any other illegal class.
module instr_encoder #(
  parameter bit ILLEGAL_NOP = 1'b0   // 1: illegal class emits a nop, 0: dropped
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_class,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err
);

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

`ifdef INSTR_ENC_LI_EN
  typedef enum logic [0:0] {IDLE, LI_LO} state_t;
`else
  typedef enum logic [0:0] {IDLE} state_t;
`endif

  state_t      state_reg, state_next;
  logic        out_valid_reg;
  logic [31:0] out_instr_reg;
  logic        err_reg;

  logic        accept, handoff;
  logic [31:0] enc_word;
  logic        enc_emit;     // accepted descriptor produces an output word
  logic        enc_illegal;
  logic        enc_li_two;   // LI needs a second (addi) word
  logic [11:0] alu_imm12;

  assign accept  = in_valid && in_ready;
  assign handoff = out_valid_reg && out_ready;

  // Shift-immediate ops carry funct7[5] in place of imm[11:5].
  assign alu_imm12 = (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                     ? {1'b0, in_funct7b5, 5'b00000, in_imm[4:0]}
                     : in_imm[11:0];

`ifdef INSTR_ENC_LI_EN
  logic [11:0] li_lo;
  logic [19:0] li_hi;
  logic        li_fits;
  logic [31:0] li_addi_word;
  logic [31:0] li_word_reg;   // addi rd,rd,lo held for the LI_LO beat

  // Upper part is rounded up when lo is negative so lui+addi sums correctly.
  assign li_lo        = in_imm[11:0];
  assign li_hi        = in_imm[31:12] + {19'd0, in_imm[11]};
  assign li_fits      = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign li_addi_word = {li_lo, in_rd, 3'b000, in_rd, OP_I};
`endif

  // Combinational encoder for the descriptor currently on the input.
  always_comb begin
    enc_word    = '0;
    enc_emit    = 1'b1;
    enc_illegal = 1'b0;
    enc_li_two  = 1'b0;
    case (in_class)
      4'd0: enc_word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      4'd1: enc_word = {alu_imm12, in_rs1, in_funct3, in_rd, OP_I};
      4'd2: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      4'd3: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      4'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], OP_BRANCH};
      4'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      4'd6: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      4'd7: enc_word = {in_imm[31:12], in_rd, OP_LUI};
      4'd8: enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
`ifdef INSTR_ENC_LI_EN
      4'd9: begin
        if (li_fits) begin
          enc_word = {li_lo, 5'd0, 3'b000, in_rd, OP_I};
        end else begin
          enc_word   = {li_hi, in_rd, OP_LUI};
          enc_li_two = (li_lo != 12'd0);
        end
      end
`endif
      default: begin
        enc_illegal = 1'b1;
        enc_emit    = ILLEGAL_NOP;
        enc_word    = NOP_WORD;
      end
    endcase
  end

  // Next-state logic and input handshake.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = !out_valid_reg || out_ready;
`ifdef INSTR_ENC_LI_EN
        if (accept && enc_li_two) state_next = LI_LO;
`endif
      end
`ifdef INSTR_ENC_LI_EN
      LI_LO: begin
        if (handoff) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State, output register and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      out_instr_reg <= '0;
      err_reg       <= 1'b0;
`ifdef INSTR_ENC_LI_EN
      li_word_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      err_reg   <= accept && enc_illegal;
`ifdef INSTR_ENC_LI_EN
      if (accept) li_word_reg <= li_addi_word;
      if (state_reg == LI_LO) begin
        // Second LI beat loads only once the lui word has been taken.
        if (handoff) begin
          out_instr_reg <= li_word_reg;
          out_valid_reg <= 1'b1;
        end
      end else
`endif
      if (accept && enc_emit) begin
        out_instr_reg <= enc_word;
        out_valid_reg <= 1'b1;
      end else if (handoff) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign err       = err_reg;

endmodule
